// File: rtl/prog_loader.sv
// Framed byte-stream loader for the risc8 program ROM: writes payload bytes as they
// arrive, checks an 8-bit additive checksum, and holds the core in reset until a good frame.
module prog_loader #(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        cnt;
  logic [7:0]        sum;
  logic              acc;

  assign acc = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (acc) begin
      case (state)
        S_IDLE:  if (in_data == HDR_BYTE) state_nx = S_ADDR;
        S_ADDR:  state_nx = S_LEN;
        S_LEN:   state_nx = S_DATA;
        S_DATA:  if (cnt == 8'd0) state_nx = S_CSUM;
        S_CSUM:  state_nx = (in_data == sum) ? S_DONE : S_ERR;
        S_DONE,
        S_ERR:   if (in_data == HDR_BYTE) state_nx = S_ADDR;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Status is a pure decode of the state register, so it changes on the accepting edge.
  always_comb begin
    done       = 1'b0;
    err        = 1'b0;
    core_rst_n = 1'b0;
    case (state)
      S_DONE: begin done = 1'b1; core_rst_n = 1'b1; end
      S_ERR:  err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      ptr       <= '0;
      cnt       <= 8'h00;
      sum       <= 8'h00;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      if (acc) begin
        case (state)
          S_ADDR: ptr <= ADDR_W'(in_data);
          S_LEN: begin
            cnt <= in_data;
            sum <= 8'h00;
          end
          S_DATA: begin
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            mem_wdata <= in_data;
            sum       <= sum + in_data;
            ptr       <= ptr + ADDR_W'(1);
            cnt       <= cnt - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as payload is driven
// and popped against each mem_we pulse; status outputs are checked after key edges.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_we, core_rst_n, done, err;
  logic [7:0] mem_addr, mem_wdata;

  prog_loader #(.HDR_BYTE(8'hA5), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_rst_n(core_rst_n), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] addr; logic [7:0] data; } wr_t;
  wr_t        sb_q[$];
  logic [7:0] payload [256];
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Every write strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb_q.size() == 0) chk("spurious_we", 1, 0);
      else begin
        wr_t e;
        e = sb_q.pop_front();
        chk("waddr", int'(mem_addr), int'(e.addr));
        chk("wdata", int'(mem_wdata), int'(e.data));
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gaps);
    if (gaps && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] start, input int n, input logic [7:0] csum,
                            input bit gaps);
    logic [7:0] a;
    send(8'hA5, gaps);
    send(start, gaps);
    send(8'(n - 1), gaps);
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      sb_q.push_back({a, payload[i]});
      send(payload[i], gaps);
    end
    send(csum, gaps);
  endtask

  task automatic chk_status(input string tag, input bit d, input bit e);
    chk({tag, "_done"}, int'(done), int'(d));
    chk({tag, "_err"}, int'(err), int'(e));
    chk({tag, "_core_rst_n"}, int'(core_rst_n), int'(d));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_mem_addr"}, int'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    chk_status(tag, 1'b0, 1'b0);
  endtask

  initial begin
    #2 chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("ready_before_edge", int'(in_ready), 0);
    @(posedge clk); #1 chk("ready_after_edge", int'(in_ready), 1);

    // Noise before header, then nominal frame
    send(8'h00, 1'b0);
    send(8'h13, 1'b0);
    chk_status("noise", 1'b0, 1'b0);
    payload[0] = 8'h20; payload[1] = 8'h41; payload[2] = 8'h42;
    send_frame(8'h00, 3, 8'hA3, 1'b0);
    chk_status("nominal", 1'b1, 1'b0);
    send(8'h77, 1'b0);
    chk_status("done_ignore", 1'b1, 1'b0);

    // Header in DONE drops core reset at the accepting edge
    send(8'hA5, 1'b0);
    chk_status("hdr_in_done", 1'b0, 1'b0);
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({8'(i), payload[i]});
      send(payload[i], 1'b0);
    end
    send(8'hA4, 1'b0);
    chk_status("bad_csum", 1'b0, 1'b1);
    send(8'h00, 1'b0);
    chk_status("err_sticky", 1'b0, 1'b1);
    send(8'hA5, 1'b0);
    chk_status("err_clear", 1'b0, 1'b0);
    send(8'h10, 1'b0);
    send(8'h00, 1'b0);
    sb_q.push_back({8'h10, 8'h5A});
    send(8'h5A, 1'b0);
    send(8'h5A, 1'b0);
    chk_status("recover", 1'b1, 1'b0);

    // Address wrap
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
    send_frame(8'hFE, 4, 8'h0A, 1'b0);
    chk_status("wrap", 1'b1, 1'b0);

    // Full-size load
    for (int i = 0; i < 256; i++) payload[i] = 8'(i);
    send_frame(8'h00, 256, 8'h80, 1'b0);
    chk_status("full", 1'b1, 1'b0);

    // Same image with random gaps
    send(8'h00, 1'b1);
    send(8'h13, 1'b1);
    send_frame(8'h00, 256, 8'h80, 1'b1);
    chk_status("gaps", 1'b1, 1'b0);

    // Reset mid-payload, then reload
    send(8'hA5, 1'b0);
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    sb_q.push_back({8'h00, 8'h11});
    send(8'h11, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    payload[0] = 8'h20; payload[1] = 8'h41; payload[2] = 8'h42;
    send_frame(8'h00, 3, 8'hA3, 1'b0);
    chk_status("reload", 1'b1, 1'b0);
    send(8'hA5, 1'b0);
    chk_status("reload_hdr", 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
